// File: rtl/mod5_frame_sequencer_if.sv
// Handshake bundle for mod5_frame_sequencer.
//   Upstream word channel : in_valid, in_ready, in_word
//   Downstream result     : out_valid, out_ready, out_remainder, out_word, divisible
// slave  : the sequencer side (accepts words, produces results).
// master : the producer/consumer side (drives words, consumes results).
interface mod5_frame_sequencer_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_word;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       out_remainder;
  logic [WIDTH-1:0] out_word;
  logic             divisible;

  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, out_remainder, out_word, divisible
  );

  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_remainder, out_word, divisible
  );
endinterface

// File: rtl/mod5_frame_sequencer.sv
// Frame sequencer wrapping a serial modulo-5 detector.
// Accepts a parallel word, clears the detector, shifts the word MSB-first into it,
// waits one cycle for the detector's registered remainder, then presents the result.
// Ports:
//   clock, reset  : clock and synchronous active-high reset
//   bus (slave)   : word input handshake and result output handshake
//   ser_bit       : serial data to the detector
//   det_en        : detector enable (high for exactly WIDTH cycles per frame)
//   det_reset     : detector reset (block reset or the CLEAR cycle)
//   det_remainder : detector's running remainder
//   check_error   : sticky mismatch flag between detector and in_word % 5
// Optional build macro MOD5_SEQ_SELFCHECK_EN enables the check_error reference;
// without it check_error is tied low.
module mod5_frame_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  mod5_frame_sequencer_if.slave bus,
  output logic                  ser_bit,
  output logic                  det_en,
  output logic                  det_reset,
  input  logic [2:0]            det_remainder,
  output logic                  check_error
);

  typedef enum logic [2:0] {StIdle, StClear, StShift, StWait, StResult} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       rem_q, rem_d;
`ifdef MOD5_SEQ_SELFCHECK_EN
  logic [2:0]       ref_q, ref_d;
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
`ifdef MOD5_SEQ_SELFCHECK_EN
    ref_d   = ref_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          shreg_d = bus.in_word;
          word_d  = bus.in_word;
`ifdef MOD5_SEQ_SELFCHECK_EN
          ref_d   = 3'(32'(bus.in_word) % 32'd5);
`endif
          state_d = StClear;
        end
      end
      StClear: begin
        cnt_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        // Detector samples shreg MSB on this same edge.
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = StWait;
      end
      StWait: begin
        // Detector remainder is registered, so it is only final one cycle after the last bit.
        rem_d   = det_remainder;
`ifdef MOD5_SEQ_SELFCHECK_EN
        if (det_remainder != ref_q) err_d = 1'b1;
`endif
        state_d = StResult;
      end
      StResult: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      shreg_q <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
`ifdef MOD5_SEQ_SELFCHECK_EN
      ref_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
`ifdef MOD5_SEQ_SELFCHECK_EN
      ref_q   <= ref_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.in_ready      = (state_q == StIdle);
  assign bus.out_valid     = (state_q == StResult);
  assign bus.out_remainder = rem_q;
  assign bus.out_word      = word_q;
  assign bus.divisible     = (state_q == StResult) && (rem_q == 3'd0);
  assign det_en            = (state_q == StShift);
  assign det_reset         = reset || (state_q == StClear);
  assign ser_bit           = (state_q == StShift) ? shreg_q[WIDTH-1] : 1'b0;

`ifdef MOD5_SEQ_SELFCHECK_EN
  assign check_error = err_q;
`else
  assign check_error = 1'b0;
`endif

endmodule

// File: tb/tb_mod5_frame_sequencer.sv
// Self-checking bench for mod5_frame_sequencer with a behavioural serial mod-5 detector.
// A negedge monitor keeps a queue of accepted words and checks every emitted result
// against word % 5, plus accept-to-valid latency.
module tb_mod5_frame_sequencer;
  localparam int unsigned Width = 8;
  localparam int unsigned Lat   = Width + 2;

  logic clk = 1'b0;
  logic rst;
  logic ser_bit, det_en, det_reset, check_error;
  logic [2:0] det_q, det_remainder;
  logic force_rem;
  logic mon_en;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  mod5_frame_sequencer_if #(.WIDTH(Width)) bus ();

  mod5_frame_sequencer #(.WIDTH(Width)) dut (
    .clock         (clk),
    .reset         (rst),
    .bus           (bus.slave),
    .ser_bit       (ser_bit),
    .det_en        (det_en),
    .det_reset     (det_reset),
    .det_remainder (det_remainder),
    .check_error   (check_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Serial detector: remainder of the bit string seen so far, MSB first.
  always @(posedge clk) begin
    if (det_reset) det_q <= 3'd0;
    else if (det_en) det_q <= 3'((32'(det_q) * 2 + 32'(ser_bit)) % 5);
  end
  assign det_remainder = force_rem ? 3'd4 : det_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard
  logic [Width-1:0] exp_word_q[$];
  int               exp_acc_q[$];
  logic             got_valid = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      exp_word_q.delete();
      exp_acc_q.delete();
      got_valid = 1'b0;
    end else if (mon_en) begin
      if (bus.out_valid && !got_valid) begin
        got_valid = 1'b1;
        if (exp_word_q.size() == 0) check("unexpected_result", 32'(bus.out_valid), 32'd0);
        else check("latency", 32'(cyc - exp_acc_q[0]), 32'(Lat));
      end
      if (bus.out_valid && bus.out_ready && exp_word_q.size() != 0) begin
        check("remainder", 32'(bus.out_remainder), 32'(exp_word_q[0]) % 5);
        check("out_word", 32'(bus.out_word), 32'(exp_word_q[0]));
        check("divisible", 32'(bus.divisible), 32'((32'(exp_word_q[0]) % 5) == 0));
        void'(exp_word_q.pop_front());
        void'(exp_acc_q.pop_front());
        got_valid = 1'b0;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_word_q.push_back(bus.in_word);
        exp_acc_q.push_back(cyc + 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!bus.in_ready && k < 60) begin
      tick();
      k++;
    end
    check("wait_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!bus.out_valid && k < 60) begin
      tick();
      k++;
    end
    check("wait_valid", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic send(input logic [Width-1:0] w);
    bus.in_word  = w;
    bus.in_valid = 1'b1;
    wait_ready();
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (!(bus.in_ready && exp_word_q.size() == 0) && k < 100) begin
      tick();
      k++;
    end
    check("drain", 32'(exp_word_q.size()), 32'd0);
  endtask

  // Streams words with in_valid held high and checks accept spacing.
  task automatic stream(input int lo, input int hi, input logic [Width-1:0] tbl[$]);
    int last_acc = -1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = lo; i <= hi; i++) begin
      bus.in_word = (tbl.size() != 0) ? tbl[i] : Width'(i);
      wait_ready();
      if (last_acc >= 0) check("accept_gap", 32'(cyc + 1 - last_acc), 32'(Width + 4));
      last_acc = cyc + 1;
      tick();
    end
    drain();
  endtask

  logic exp_err;
  logic [Width-1:0] tbl[$];
  logic [Width-1:0] none[$];

  initial begin
`ifdef MOD5_SEQ_SELFCHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    rst = 1'b1;
    force_rem = 1'b0;
    mon_en = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_word = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    // Reset state
    check("rst_det_reset", 32'(det_reset), 32'd1);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_rem", 32'(bus.out_remainder), 32'd0);
    check("rst_out_word", 32'(bus.out_word), 32'd0);
    check("rst_det_en", 32'(det_en), 32'd0);
    check("rst_check_err", 32'(check_error), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_det_reset", 32'(det_reset), 32'd0);

    // 1: 0xFF
    bus.out_ready = 1'b1;
    send(8'hFF);
    check("clear_det_reset", 32'(det_reset), 32'd1);
    tick();
    check("shift_det_en", 32'(det_en), 32'd1);
    check("shift_ser_bit", 32'(ser_bit), 32'd1);
    wait_valid();
    check("t1_rem", 32'(bus.out_remainder), 32'd0);
    check("t1_div", 32'(bus.divisible), 32'd1);
    drain();

    // 2: back-to-back
    tbl = '{8'h07, 8'hC8, 8'hC9, 8'h00};
    stream(0, 3, tbl);

    // 3: backpressure
    bus.out_ready = 1'b0;
    send(8'h0D);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_rem", 32'(bus.out_remainder), 32'd3);
      check("bp_word", 32'(bus.out_word), 32'h0D);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp_release_idle", 32'(bus.in_ready), 32'd1);
    check("bp_release_valid", 32'(bus.out_valid), 32'd0);

    // 4: reset mid-frame on the 4th SHIFT cycle
    send(8'hAA);
    repeat (4) tick();
    check("mid_det_en", 32'(det_en), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_det_reset", 32'(det_reset), 32'd1);
    tick();
    rst = 1'b0;
    check("mid_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_out_valid", 32'(bus.out_valid), 32'd0);
    begin
      int seen = 0;
      for (int i = 0; i < 15; i++) begin
        tick();
        if (bus.out_valid) seen++;
      end
      check("mid_no_result", 32'(seen), 32'd0);
    end
    send(8'h0B);
    wait_valid();
    check("t4_rem", 32'(bus.out_remainder), 32'd1);
    drain();

    // Randomized traffic with random gaps and stalls
    for (int i = 0; i < 800; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_word   = Width'($urandom);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    drain();

    // 5: exhaustive sweep
    stream(0, 255, none);
    check("sweep_check_err", 32'(check_error), 32'd0);

    // 6: corrupted detector remainder
    mon_en = 1'b0;
    force_rem = 1'b1;
    bus.out_ready = 1'b0;
    send(8'h05);
    wait_valid();
    check("force_rem_pass", 32'(bus.out_remainder), 32'd4);
    check("force_err", 32'(check_error), 32'(exp_err));
    bus.out_ready = 1'b1;
    tick();
    force_rem = 1'b0;
    mon_en = 1'b1;
    send(8'h07);
    drain();
    check("err_sticky", 32'(check_error), 32'(exp_err));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("err_cleared", 32'(check_error), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
